// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and sizing helpers.
// Intended to be imported by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DELIVER,
    WAIT_IDLE
  } rx_state_t;

  function automatic int cnt_width(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain for the raw rx pin plus a 3-tap history used for
// mid-bit majority voting.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_pin,
  output logic rx_s,
  output logic maj
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic [1:0]             hist_reg;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_head
      assign sync_next[gi] = rx_pin;
    end else begin : g_tail
      assign sync_next[gi] = sync_reg[gi-1];
    end
  end

  // Preset to 1 so the line reads idle straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '1;
      hist_reg <= '1;
    end else begin
      sync_reg <= sync_next;
      hist_reg <= {hist_reg[0], rx_s};
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  assign maj  = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with majority-voted mid-bit sampling, a one-deep
// valid/ready holding register, framing-error flag and overrun pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int CW  = cnt_width(CLKS_PER_BIT);
  localparam int IW  = $clog2(UART_DATA_BITS);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] SAMPLE_AT = CW'(MID + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  // START is entered one cycle after the edge, so the counter runs one
  // behind the true bit position until the start bit is confirmed.
  localparam logic [CW-1:0] REALIGN   = CW'((MID + 3) % CLKS_PER_BIT);
  localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_BITS - 1);

  logic rx_s;
  logic maj;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .rx_pin(rx_pin),
    .rx_s  (rx_s),
    .maj   (maj)
  );

  rx_state_t           state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next, cnt_inc;
  logic [IW-1:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]          shift_reg, shift_next;
  logic                frame_bad_reg, frame_bad_next;
  logic                at_sample;

  logic [7:0]          rx_data_reg;
  logic                rx_valid_reg;
  logic                rx_frame_err_reg;
  logic                rx_overrun_reg;
  logic                deliver_load;
  logic                deliver_drop;
  logic                consume;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_bad_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_bad_reg <= frame_bad_next;
    end
  end

  assign cnt_inc   = (cnt_reg == LAST_CNT) ? '0 : cnt_reg + CW'(1);
  assign at_sample = (cnt_reg == SAMPLE_AT);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_inc;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    frame_bad_next = frame_bad_reg;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (at_sample) begin
          if (maj) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            cnt_next     = REALIGN;
            bit_idx_next = '0;
          end
        end
      end
      DATA: begin
        if (at_sample) begin
          shift_next[bit_idx_reg] = maj;
          if (bit_idx_reg == LAST_IDX) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IW'(1);
          end
        end
      end
      STOP: begin
        if (at_sample) begin
          frame_bad_next = ~maj;
          state_next     = DELIVER;
        end
      end
      DELIVER: begin
        state_next = frame_bad_reg ? WAIT_IDLE : IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_busy      = (state_reg != IDLE);
    deliver_load = (state_reg == DELIVER) && (!rx_valid_reg || rx_ready);
    deliver_drop = (state_reg == DELIVER) && rx_valid_reg && !rx_ready;
    consume      = (state_reg != DELIVER) && rx_valid_reg && rx_ready;
  end

  // A full, unconsumed holding register keeps the older byte and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_overrun_reg   <= 1'b0;
    end else begin
      rx_overrun_reg <= deliver_drop;
      if (deliver_load) begin
        rx_data_reg      <= shift_reg;
        rx_frame_err_reg <= frame_bad_reg;
        rx_valid_reg     <= 1'b1;
      end else if (consume) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_overrun   = rx_overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames at nominal and +/-3%
// baud, then hand-written sequences for back-to-back, glitch, break, overrun and reset.
module tb_uart_rx;

  localparam int CPB    = 16;
  localparam int CLK_T  = 10;
  localparam int BIT_T  = CPB * CLK_T;
  localparam int LAT_MAX = (CPB * 19) / 2 + 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  always #(CLK_T / 2) clk = ~clk;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_pin      (rx_pin),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_busy     (rx_busy)
  );

  int checks = 0;
  int errors = 0;

  // Free-running observers; the stimulus thread only reads them.
  int         cyc = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         ov_cycles = 0;
  int         ov_pulses = 0;
  int         busy_cycles = 0;
  logic       valid_q = 1'b0;
  logic       ov_q = 1'b0;
  logic [8:0] got_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_valid && !valid_q) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    valid_q = rx_valid;
    if (rx_overrun) begin
      ov_cycles++;
      if (!ov_q) ov_pulses++;
    end
    ov_q = rx_overrun;
    if (rx_busy) busy_cycles++;
    if (rx_valid && rx_ready) got_q.push_back({rx_frame_err, rx_data});
  end

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         bit_t;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] tiny[4];
  logic [7:0] partial;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected <= %0d", name, act, lim);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_t,
                            input int hold_low_bits);
    rx_pin = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      #(bit_t);
    end
    rx_pin = stop_bit;
    #(bit_t);
    if (hold_low_bits > 0) #(hold_low_bits * bit_t);
    rx_pin = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, rx_valid, 1);
  endtask

  task automatic consume();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc;
    int r0;
    int b0;
    int ov0;
    int oc0;
    int rd;
    int c0;
    int n;
    logic [8:0] got;

    vecs[0] = '{8'h54, 1'b1, 160, 8'h54, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 155, 8'hA5, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 165, 8'h3C, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 160, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 165, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 155, 8'h80, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 160, 8'h01, 1'b0};
    vecs[7] = '{8'hC3, 1'b0, 160, 8'hC3, 1'b1};
    tiny[0] = 8'h54;
    tiny[1] = 8'h69;
    tiny[2] = 8'h6E;
    tiny[3] = 8'h79;
    partial = 8'hE5;

    reset    = 1'b1;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_data", rx_data, 0);
    check("reset rx_frame_err", rx_frame_err, 0);
    check("reset rx_overrun", rx_overrun, 0);
    check("reset rx_busy", rx_busy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);

    for (int v = 0; v < 8; v++) begin
      align();
      start_cyc = cyc + 1;
      send_frame(vecs[v].data, vecs[v].stop_bit, vecs[v].bit_t, 0);
      wait_valid($sformatf("vec%0d valid", v));
      check($sformatf("vec%0d data", v), rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d frame_err", v), rx_frame_err, vecs[v].exp_err);
      if (vecs[v].bit_t == BIT_T)
        check_le($sformatf("vec%0d latency", v), rise_cyc - start_cyc, LAT_MAX);
      consume();
      @(negedge clk);
      check($sformatf("vec%0d consumed", v), rx_valid, 0);
      $display("vec%0d sent 0x%02h stop=%0d bit_t=%0d -> 0x%02h err=%0d",
               v, vecs[v].data, vecs[v].stop_bit, vecs[v].bit_t, rx_data, rx_frame_err);
      repeat (2 * CPB) @(posedge clk);
    end

    // Back-to-back "Tiny" with the consumer always ready.
    rx_ready = 1'b1;
    rd  = got_q.size();
    ov0 = ov_pulses;
    align();
    for (int i = 0; i < 4; i++) send_frame(tiny[i], 1'b1, BIT_T, 0);
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    check("b2b count", got_q.size() - rd, 4);
    for (int i = 0; i < 4; i++) begin
      got = (rd + i < got_q.size()) ? got_q[rd + i] : 9'h1FF;
      check($sformatf("b2b byte%0d", i), got, {1'b0, tiny[i]});
    end
    check("b2b overrun", ov_pulses - ov0, 0);
    $display("b2b Tiny received %0d bytes", got_q.size() - rd);
    rx_ready = 1'b0;
    repeat (CPB) @(posedge clk);

    // Five-cycle glitch on an idle line.
    r0 = rise_cnt;
    b0 = busy_cycles;
    align();
    rx_pin = 1'b0;
    #(5 * CLK_T);
    rx_pin = 1'b1;
    n = 0;
    @(negedge clk);
    while (rx_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("glitch busy clears", rx_busy, 0);
    check("glitch busy seen", (busy_cycles - b0) > 0, 1);
    repeat (12 * CPB) @(posedge clk);
    check("glitch no byte", rise_cnt - r0, 0);
    align();
    send_frame(8'h41, 1'b1, BIT_T, 0);
    wait_valid("post-glitch valid");
    check("post-glitch data", rx_data, 8'h41);
    check("post-glitch frame_err", rx_frame_err, 0);
    $display("glitch ignored, then 0x%02h received", rx_data);
    consume();
    repeat (2 * CPB) @(posedge clk);

    // Bad stop bit followed by a long break.
    r0 = rise_cnt;
    align();
    fork
      send_frame(8'h55, 1'b0, BIT_T, 40);
      begin
        #(20 * BIT_T);
        check("break valid", rx_valid, 1);
        check("break data", rx_data, 8'h55);
        check("break frame_err", rx_frame_err, 1);
        check("break busy", rx_busy, 1);
        consume();
        #(15 * BIT_T);
        check("break single byte", rise_cnt - r0, 1);
        check("break nothing pending", rx_valid, 0);
      end
    join
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("break released busy", rx_busy, 0);
    align();
    send_frame(8'h66, 1'b1, BIT_T, 0);
    wait_valid("after-break valid");
    check("after-break data", rx_data, 8'h66);
    check("after-break frame_err", rx_frame_err, 0);
    $display("break: one 0x55 with frame_err, then 0x%02h", rx_data);
    consume();
    repeat (2 * CPB) @(posedge clk);

    // Overrun: second byte dropped while the first is unconsumed.
    ov0 = ov_pulses;
    oc0 = ov_cycles;
    align();
    send_frame(8'h31, 1'b1, BIT_T, 0);
    #(2 * BIT_T);
    send_frame(8'h32, 1'b1, BIT_T, 0);
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("overrun kept data", rx_data, 8'h31);
    check("overrun valid", rx_valid, 1);
    check("overrun pulses", ov_pulses - ov0, 1);
    check("overrun width", ov_cycles - oc0, 1);
    $display("overrun: held 0x%02h, pulses=%0d", rx_data, ov_pulses - ov0);
    consume();
    repeat (2 * CPB) @(posedge clk);

    // Consumer ready exactly in the DELIVER cycle of the second byte.
    ov0 = ov_pulses;
    align();
    send_frame(8'h31, 1'b1, BIT_T, 0);
    wait_valid("same-cycle first valid");
    repeat (2 * CPB) @(posedge clk);
    rd = got_q.size();
    align();
    c0 = cyc;
    fork
      send_frame(8'h32, 1'b1, BIT_T, 0);
      begin
        wait (cyc == c0 + 156);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    repeat (CPB) @(posedge clk);
    @(negedge clk);
    check("same-cycle data", rx_data, 8'h32);
    check("same-cycle valid", rx_valid, 1);
    check("same-cycle overrun", ov_pulses - ov0, 0);
    got = (rd < got_q.size()) ? got_q[rd] : 9'h1FF;
    check("same-cycle consumed old", got, {1'b0, 8'h31});
    $display("same-cycle: consumed 0x%02h, now holding 0x%02h", got[7:0], rx_data);
    consume();
    repeat (2 * CPB) @(posedge clk);

    // Reset in the middle of bit 4 with a byte already pending.
    align();
    send_frame(8'hEE, 1'b1, BIT_T, 0);
    wait_valid("pre-reset pending valid");
    repeat (CPB) @(posedge clk);
    align();
    rx_pin = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 5; i++) begin
      rx_pin = partial[i];
      if (i < 4) #(BIT_T);
    end
    #(BIT_T / 2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midreset%0d valid", i), rx_valid, 0);
      check($sformatf("midreset%0d data", i), rx_data, 0);
      check($sformatf("midreset%0d frame_err", i), rx_frame_err, 0);
      check($sformatf("midreset%0d overrun", i), rx_overrun, 0);
      check($sformatf("midreset%0d busy", i), rx_busy, 0);
    end
    @(posedge clk);
    #1;
    rx_pin = 1'b1;
    reset  = 1'b0;
    r0 = rise_cnt;
    repeat (20 * CPB) @(posedge clk);
    check("post-reset no byte", rise_cnt - r0, 0);
    align();
    send_frame(8'h0A, 1'b1, BIT_T, 0);
    wait_valid("post-reset valid");
    check("post-reset data", rx_data, 8'h0A);
    check("post-reset frame_err", rx_frame_err, 0);
    check("post-reset single byte", rise_cnt - r0, 1);
    $display("mid-frame reset: only 0x%02h reported", rx_data);
    consume();
    repeat (CPB) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Counterpart to the team's text-stream UART transmitter.
- Samples one asynchronous serial line and recovers bytes with mid-bit majority voting.
- Presents each byte on a one-deep valid/ready output register.
- Reports framing errors and overruns. Sits between the chip's rx pin and any byte consumer, such as a text checker or loopback logic.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Legal range 4..1023. Counter width is $clog2(CLKS_PER_BIT).
- SYNC_STAGES, 2: number of metastability flops on rx_pin. Legal range 2..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_pin  in  1  asynchronous serial input; idle high
- rx_data  out  8  received byte, LSB first on the wire
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready
- rx_frame_err  out  1  qualifies rx_data: stop bit sampled low
- rx_overrun  out  1  one-cycle pulse: a byte was dropped because the holding register was full
- rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; rx_valid=0, rx_data=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
  - Synchronizer flops preset to 1, so the line reads idle.
- Synchronizer: rx_pin passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Majority sample: maj = majority of rx_s at cycles mid-1, mid, mid+1, where mid = CLKS_PER_BIT/2 (integer divide) within the bit period.
- State machine:
  - IDLE: on rx_s==0, go to START and clear the cycle counter.
  - START: at mid+1, evaluate maj.
    - maj==1 (glitch): return to IDLE, no output.
    - maj==0: go to DATA with bit_idx=0, and realign the counter so later samples land mid-bit.
  - DATA: at each bit's mid+1, shift maj into bit position bit_idx (LSB first). After bit_idx==7, go to STOP.
  - STOP: at mid+1, latch frame_bad = ~maj, then go to DELIVER.
  - DELIVER (1 cycle): perform the output write (see below).
    - If frame_bad==0, go to IDLE.
    - If frame_bad==1, go to WAIT_IDLE.
  - WAIT_IDLE (break / low line): stay until rx_s==1, then go to IDLE. No new start is detected while the line stays low.
- Output write in DELIVER:
  - If !rx_valid, or rx_valid && rx_ready in the same cycle: load rx_data and rx_frame_err; rx_valid=1.
  - Else (full, not being consumed): drop the new byte, keep the old byte and flags, pulse rx_overrun=1 for exactly one cycle.
- Consumption: rx_valid && rx_ready outside DELIVER clears rx_valid next cycle. rx_data holds its value until overwritten.
- Latency: rx_valid rises 2 cycles after the stop-bit mid+1 sample cycle (STOP sample, then DELIVER). Total from the rx_pin falling edge is about SYNC_STAGES + 9.5*CLKS_PER_BIT + 2 cycles.
- Back-to-back frames: a start bit arriving immediately after a good stop bit must be caught. IDLE is entered before mid of the next bit, which holds because CLKS_PER_BIT>=4.
- Reset mid-frame: the frame is abandoned with no partial output. An rx_valid byte that is pending at reset is lost.
- Bit 7 is received as sent; no value is assumed for the MSB.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, DELIVER, WAIT_IDLE)
  - UART_DATA_BITS=8
  - localparam function for the counter width
  - the same package is shared with the transmitter going forward
- Sub-module uart_rx_sync contains the SYNC_STAGES flop chain plus the 3-tap majority shift register. It outputs rx_s and maj.
- The FSM, counters and output register stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=16: send 0x54 ("T") framed 0,00101010,1 -> rx_valid with rx_data=0x54 and rx_frame_err=0. Valid arrives within 16*9.5+4 cycles of the start edge.
- Hold rx_ready=1 and send "Tiny" back-to-back with no idle gap -> 0x54, 0x69, 0x6E, 0x79 in order, no overrun.
- Drive a 5-cycle low glitch on an idle line -> no rx_valid, rx_busy returns to 0 within 10 cycles, and the next real 0x41 is received correctly.
- Send 0x55 with the stop bit low, then hold the line low for 40 bit-times -> one byte 0x55 with rx_frame_err=1. No further bytes until the line goes high and a new frame is sent.
- Hold rx_ready=0 and send 0x31 then 0x32 -> rx_data stays 0x31 and rx_overrun pulses once for exactly 1 cycle. Raising rx_ready in the same cycle as the second DELIVER instead yields 0x32 with no overrun.
- Assert reset during bit 4 of a frame, then send 0x0A -> only 0x0A is reported. Every output was 0 during reset.
- Cover ±3% baud mismatch (CLKS_PER_BIT=16 with the stimulus bit period at 15.5 and at 16.5 cycles) -> correct bytes.
